// File: rtl/ir_tx_arbiter_if.sv
// Request/grant and IR transmitter bundle for the IR TX arbiter.
// master = arbiter side, slave = requesters and transmitter side.
interface ir_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [31:0] req_cmd;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic        tx_send;
  logic [7:0]  tx_addr;
  logic [7:0]  tx_cmd;
  logic        tx_busy;
  logic        active;

  modport master (
    input  req,
    input  req_addr,
    input  req_cmd,
    input  tx_busy,
    output gnt,
    output ack,
    output err,
    output tx_send,
    output tx_addr,
    output tx_cmd,
    output active
  );

  modport slave (
    output req,
    output req_addr,
    output req_cmd,
    output tx_busy,
    input  gnt,
    input  ack,
    input  err,
    input  tx_send,
    input  tx_addr,
    input  tx_cmd,
    input  active
  );
endinterface

// File: rtl/ir_tx_arbiter.sv
// Round-robin arbiter sharing one NEC IR transmitter among
// four requesters, with start timeout and inter-frame gap.
module ir_tx_arbiter #(
  parameter int GAP_CYCLES    = 2025000,
  parameter int START_TIMEOUT = 5000
) (
  input  logic clk,
  input  logic rst,
  ir_tx_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  localparam logic [21:0] TO_LAST  =
    22'(START_TIMEOUT - 1);
  localparam logic [21:0] GAP_LAST =
    22'(GAP_CYCLES - 1);

  state_t      state;
  state_t      state_d;
  logic [21:0] timer;
  logic [21:0] timer_d;
  logic [21:0] timer_inc;
  logic [1:0]  last_ptr;
  logic [1:0]  last_ptr_d;
  logic [1:0]  sel;
  logic [1:0]  cand;
  logic        found;

  logic [3:0]  gnt_q;
  logic [3:0]  gnt_d;
  logic [3:0]  ack_q;
  logic [3:0]  ack_d;
  logic [3:0]  err_q;
  logic [3:0]  err_d;
  logic        send_q;
  logic        send_d;
  logic [7:0]  addr_q;
  logic [7:0]  addr_d;
  logic [7:0]  cmd_q;
  logic [7:0]  cmd_d;
  logic        active_q;
  logic        active_d;

  logic        go_issue;
  logic        go_done;
  logic        go_tmo;

  assign timer_inc = (timer == '1) ?
    timer : timer + 22'd1;

  // search starts just past the last winner
  always_comb begin
    sel   = last_ptr;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_ptr + 2'(i);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      last_ptr <= 2'd3;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      send_q   <= 1'b0;
      addr_q   <= '0;
      cmd_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      last_ptr <= last_ptr_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      send_q   <= send_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    unique case (state)
      IDLE: begin
        if (found) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        timer_d = '0;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer == TO_LAST) begin
          state_d = GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = GAP;
          timer_d = '0;
        end
      end
      GAP: begin
        if (timer == GAP_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign go_issue = (state == IDLE) &&
                    (state_d == ISSUE);
  assign go_done  = (state == WAIT_DONE) &&
                    (state_d == GAP);
  assign go_tmo   = (state == WAIT_BUSY) &&
                    (state_d == GAP);

  always_comb begin
    gnt_d      = gnt_q;
    ack_d      = '0;
    err_d      = '0;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    last_ptr_d = last_ptr;
    send_d     = (state_d == ISSUE);
    active_d   = (state_d != IDLE);
    unique case (1'b1)
      go_issue: begin
        gnt_d      = 4'b0001 << sel;
        addr_d     = bus.req_addr[{sel, 3'b000} +: 8];
        cmd_d      = bus.req_cmd[{sel, 3'b000} +: 8];
        last_ptr_d = sel;
      end
      go_done: begin
        ack_d = gnt_q;
        gnt_d = '0;
      end
      go_tmo: begin
        err_d = gnt_q;
        gnt_d = '0;
      end
      default: begin
        gnt_d = gnt_q;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.tx_send = send_q;
  assign bus.tx_addr = addr_q;
  assign bus.tx_cmd  = cmd_q;
  assign bus.active  = active_q;

endmodule

// File: tb/tb_ir_tx_arbiter.sv
// Scoreboard bench for ir_tx_arbiter: round-robin model,
// transmitter model, latency and gap checks.
module tb_ir_tx_arbiter;

  localparam int GAP = 8;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ir_tx_arbiter_if bus();

  ir_tx_arbiter #(
    .GAP_CYCLES(GAP),
    .START_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] addr;
    logic [7:0] cmd;
    bit         is_err;
    bit         b2b;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   m_ptr    = 3;
  bit   no_busy  = 1'b0;
  int   fall_cyc = -100;
  int   send_cyc = -100;
  int   end_cyc  = -1000;
  int   left     = 0;
  bit   start    = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL watchdog actual=%0d required<60000",
               cyc);
      $fatal(1);
    end
  end

  // transmitter: busy from the cycle after send, 20 cycles
  always @(negedge clk) begin
    if (rst) begin
      bus.tx_busy = 1'b0;
      left  = 0;
      start = 1'b0;
    end else begin
      if (left > 0) begin
        left--;
        if (left == 0) begin
          bus.tx_busy = 1'b0;
          fall_cyc = cyc;
        end
      end
      if (start) begin
        start = 1'b0;
        bus.tx_busy = 1'b1;
        left = 20;
      end
      if (bus.tx_send && !no_busy) start = 1'b1;
    end
  end

  // monitor
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] oh;
    if (!rst) begin
      if (bus.tx_send) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_send", 1, 0);
        end else begin
          e = exp_q[0];
          oh = 4'b0001 << e.idx;
          chk("send_gnt", bus.gnt, oh);
          chk("send_addr", bus.tx_addr, e.addr);
          chk("send_cmd", bus.tx_cmd, e.cmd);
          if (e.b2b)
            chk("gap_exact", cyc - end_cyc, 9);
          else
            chk("gap_min", cyc - end_cyc >= 9, 1);
        end
        send_cyc = cyc;
      end
      if (bus.ack != 0 || bus.err != 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done",
              {bus.ack, bus.err}, 0);
        end else begin
          e = exp_q.pop_front();
          oh = 4'b0001 << e.idx;
          chk("ack", bus.ack, e.is_err ? 4'b0 : oh);
          chk("err", bus.err, e.is_err ? oh : 4'b0);
          chk("hold_addr_cmd",
              {bus.tx_addr, bus.tx_cmd},
              {e.addr, e.cmd});
          chk("gnt_clear", bus.gnt, 0);
          if (e.is_err)
            chk("timeout_lat", cyc - send_cyc, 17);
          else
            chk("ack_lat", cyc - fall_cyc, 1);
        end
        end_cyc = cyc;
      end
    end
  end

  task automatic start_round(input logic [3:0] mask,
                             input bit nob,
                             input bit fixed,
                             input logic [7:0] fa,
                             input logic [7:0] fc);
    logic [3:0] pend;
    logic [7:0] a;
    logic [7:0] c8;
    bit first;
    int c;
    exp_t e;
    no_busy = nob;
    for (int i = 0; i < 4; i++) begin
      a  = fixed ? fa : 8'($urandom);
      c8 = fixed ? fc : 8'($urandom);
      bus.req_addr[8*i +: 8] = a;
      bus.req_cmd[8*i +: 8]  = c8;
    end
    pend  = mask;
    first = 1'b1;
    c     = m_ptr;
    while (pend != 0) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_ptr + k) % 4;
        if (pend[c]) break;
      end
      e.idx    = c;
      e.addr   = bus.req_addr[8*c +: 8];
      e.cmd    = bus.req_cmd[8*c +: 8];
      e.is_err = nob;
      e.b2b    = !first;
      exp_q.push_back(e);
      pend[c] = 1'b0;
      m_ptr   = c;
      first   = 1'b0;
    end
    bus.req = mask;
  endtask

  task automatic finish_round(input bit scr,
                              input logic [3:0] drop);
    int n  = 0;
    int bc = 0;
    while (bus.req != 0 && n < 3000) begin
      @(negedge clk);
      n++;
      bus.req &= ~(bus.ack | bus.err);
      if (bus.tx_busy) bc++;
      else bc = 0;
      if (drop != 0 && bc >= 3) bus.req &= ~drop;
      if (scr && bus.gnt != 0) begin
        bus.req_addr = $urandom;
        bus.req_cmd  = $urandom;
      end
    end
    while ((bus.active || exp_q.size() != 0) &&
           n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("round_timeout", n < 3000, 1);
    no_busy = 1'b0;
  endtask

  initial begin
    bit bad;
    int n;
    int bc;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_cmd  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {bus.gnt, bus.ack, bus.err, bus.tx_send,
         bus.tx_addr, bus.tx_cmd, bus.active}, 0);
    rst = 1'b0;

    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.gnt != 0 || bus.tx_send ||
          bus.active || bus.ack != 0)
        bad = 1'b1;
    end
    chk("idle_no_req", bad, 0);

    start_round(4'b1111, 0, 0, 0, 0);
    finish_round(0, 0);

    start_round(4'b0001, 0, 1, 8'h86, 8'h12);
    finish_round(1, 0);

    start_round(4'b0100, 1, 0, 0, 0);
    finish_round(0, 0);

    start_round(4'b0100, 0, 0, 0, 0);
    finish_round(0, 4'b0100);

    start_round(4'b0011, 0, 0, 0, 0);
    n  = 0;
    bc = 0;
    while (bc < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.tx_busy) bc++;
      else bc = 0;
    end
    chk("busy_wait", n < 200, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_midframe",
        {bus.gnt, bus.ack, bus.err, bus.tx_send,
         bus.tx_addr, bus.tx_cmd, bus.active}, 0);
    bus.req = '0;
    exp_q.delete();
    m_ptr = 3;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_round(4'b1010, 0, 0, 0, 0);
    finish_round(0, 0);

    repeat (25) begin
      start_round(4'($urandom_range(1, 15)),
                  $urandom_range(0, 4) == 0,
                  0, 0, 0);
      finish_round(0, 0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_tx_arbiter.md
IR_TX_ARBITER -- requirements
Module: ir_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 2025000, minimum idle clk cycles between frames (40.5 ms at 50 MHz).
REQ-002 Parameter START_TIMEOUT, default 5000, max clk cycles from tx_send to tx_busy rising.
REQ-003 Port clk, input, 1, 50 MHz clock; the only clock.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port req, input, 4, per-requester frame request; held high until ack.
REQ-006 Port req_addr, input, 32, four 8-bit NEC addresses; requester i uses bits [8i+7:8i].
REQ-007 Port req_cmd, input, 32, four 8-bit NEC commands; requester i uses bits [8i+7:8i].
REQ-008 Port gnt, output, 4, one-hot grant; held from selection through ack.
REQ-009 Port ack, output, 4, one-cycle completion pulse to the granted requester.
REQ-010 Port err, output, 4, one-cycle start-timeout pulse to the granted requester.
REQ-011 Port tx_send, output, 1, one-cycle start strobe to the IR transmitter.
REQ-012 Port tx_addr, output, 8, latched address to the transmitter.
REQ-013 Port tx_cmd, output, 8, latched command to the transmitter.
REQ-014 Port tx_busy, input, 1, transmitter frame-in-progress flag.
REQ-015 Port active, output, 1, high in every state except IDLE.

Function
REQ-016 Five states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP. All outputs are registered.
REQ-017 IDLE, any req bit set: select a requester round-robin, searching from last_ptr+1 upward mod 4.
REQ-018 On that selection: set gnt, latch tx_addr/tx_cmd from the selected slice, set last_ptr, go to ISSUE.
REQ-019 IDLE with req==0: remain in IDLE; gnt, tx_send, ack and err stay 0.
REQ-020 ISSUE lasts exactly one cycle with tx_send=1, then goes to WAIT_BUSY with the timer cleared.
REQ-021 tx_send is never high outside ISSUE.
REQ-022 WAIT_BUSY, tx_busy=1: go to WAIT_DONE.
REQ-023 WAIT_BUSY, tx_busy=0 and timer==START_TIMEOUT-1: pulse err[gnt] for one cycle, clear gnt, go to GAP.
REQ-024 WAIT_BUSY otherwise: timer increments.
REQ-025 WAIT_DONE, tx_busy falling (1 then 0): pulse ack[gnt] for one cycle, clear gnt, go to GAP with timer=0.
REQ-026 GAP: timer counts to GAP_CYCLES-1, then goes to IDLE. Requests are not sampled during GAP.
REQ-027 req_addr, req_cmd and req are ignored after latching. Dropping req mid-frame does not abort the frame; ack still pulses.
REQ-028 ack and err are never both high, and at most one bit of each is high.
REQ-029 Timer is 22 bits wide and saturates; no wrap-around in any state.
REQ-030 Simultaneous requests are served one per frame in round-robin order; no requester is starved.

Reset
REQ-031 While rst=1: state=IDLE, timer=0, last_ptr=3, gnt=0, ack=0, err=0, tx_send=0, tx_addr=0, tx_cmd=0, active=0.
REQ-032 Reset mid-frame drops the transaction: no ack or err is issued for it.
REQ-033 The first grant after reset honours req0 first.

Verification (GAP_CYCLES=8, START_TIMEOUT=16, transmitter model busy 1 cycle after send for 20 cycles)
REQ-034 Single request:
- Stimulus: req=0001, addr0=86, cmd0=12.
- Response: tx_send pulses once with tx_addr=86, tx_cmd=12.
- Response: ack=0001 one cycle after tx_busy falls.
- Response: next grant no sooner than 8 cycles later.
REQ-035 Contention:
- Stimulus: req=1111 held continuously.
- Response: grant order 0,1,2,3,0.
- Response: each frame separated by at least 8 GAP cycles.
REQ-036 Timeout:
- Stimulus: model never raises busy, req=0100.
- Response: err=0100 exactly 16 cycles after WAIT_BUSY entry.
- Response: no ack; GAP then IDLE.
REQ-037 Mid-frame request drop:
- Stimulus: req2 drops during WAIT_DONE.
- Response: frame completes and ack=0100 still pulses.
REQ-038 Reset mid-frame:
- Stimulus: rst asserted in WAIT_DONE.
- Response: all outputs 0 next cycle.
- Response: with req=1010 after release, req1 is granted first.
REQ-039 Input stability:
- Stimulus: change addr/cmd after grant.
- Response: tx_addr/tx_cmd unchanged until the next grant.
